// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the generic bus responder.
// State encoding, legal byte-enable patterns and LFSR constants.
package bus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Fibonacci taps 16,14,13,11 as a mask over q[15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Illegal byte-enable pattern or size/alignment mismatch
  function automatic logic be_misuse(
    input logic [3:0] be,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b1;
    unique case (be)
      BE_B0, BE_B1,
      BE_B2, BE_B3: bad = 1'b0;
      BE_H0, BE_H1: bad = lo[0];
      BE_W:         bad = (lo != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_resp_lfsr.sv
// 16-bit Fibonacci LFSR for randomised wait states.
// Steps once per asserted adv; exposes the low nibble.
module bus_resp_lfsr
  import bus_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [3:0] low
);

  logic [15:0] q;

  // Shift left, feedback from the tap mask parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (adv) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

  assign low = q[3:0];

endmodule

// File: rtl/generic_bus_responder.sv
// Word-addressed data-memory responder with programmable wait states.
// Define BUS_RESP_RAND_LAT_EN for LFSR-randomised wait counts.
module generic_bus_responder
  import bus_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          req;
  logic          accept;
  logic          complete;
  logic          fault;
  logic          commit;
  logic [3:0]    wait_cnt;
  logic [32:0]   diff;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req    = ren | wen;
  assign accept = req && (state_q == IDLE);

`ifdef BUS_RESP_RAND_LAT_EN
  logic [3:0] rnd;

  bus_resp_lfsr u_lfsr (
    .clk   (CLK),
    .rst_n (nRST),
    .adv   (accept),
    .low   (rnd)
  );

  assign wait_cnt = (rnd > LAT) ? LAT : rnd;
`else
  assign wait_cnt = LAT;
`endif

  // State and wait counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and completion strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (wait_cnt == 4'd0) begin
            complete = 1'b1;
          end else begin
            cnt_d   = wait_cnt - 4'd1;
            state_d = (wait_cnt == 4'd1) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        cnt_d    = '0;
        complete = req;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign diff = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign off  = diff[31:0];
  assign idx  = off[AW+1:2];

  // Range, size/alignment and ren+wen collision faults
  always_comb begin
    fault = 1'b0;
    if (diff[32] || ({1'b0, off} >= SPAN)) begin
      fault = 1'b1;
    end
    if (be_misuse(byte_en, addr[1:0])) begin
      fault = 1'b1;
    end
    if (ren && wen) begin
      fault = 1'b1;
    end
  end

  // A responder held in reset never answers
  assign busy   = nRST && req && !complete;
  assign error  = nRST && complete && fault;
  assign commit = nRST && complete && wen && !fault;

  assign rdata = (nRST && complete && ren && !wen && !fault)
               ? mem[idx] : '0;

  // Byte-lane store, committed at the completion edge
  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_generic_bus_responder.sv
// Directed bench for generic_bus_responder.
// Instances with LATENCY=2 (d2) and LATENCY=0 (d0) share inputs.
module tb_generic_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata2;
  logic        busy2;
  logic        error2;
  logic [31:0] rdata0;
  logic        busy0;
  logic        error0;

  int vectors;
  int miscompares;

  generic_bus_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (2)
  ) d2 (
    .CLK     (clk),
    .nRST    (rst_n),
    .ren     (ren),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .byte_en (byte_en),
    .rdata   (rdata2),
    .busy    (busy2),
    .error   (error2)
  );

  generic_bus_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (0)
  ) d0 (
    .CLK     (clk),
    .nRST    (rst_n),
    .ren     (ren),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .byte_en (byte_en),
    .rdata   (rdata0),
    .busy    (busy0),
    .error   (error0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One d2 transaction: inputs set at edge+1, sampled at edge+3
  task automatic op2(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    output int          n,
    output logic [31:0] rd,
    output logic        er
  );
    ren = r;
    wen = w;
    addr = a;
    wdata = d;
    byte_en = be;
    n = 0;
    #2;
    while (busy2 === 1'b1 && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    rd = rdata2;
    er = error2;
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL op2_timeout busy=%b cycles=%0d required completion",
               busy2, n);
    end
    @(posedge clk);
    #1;
    ren = 1'b0;
    wen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ren = 1'b0;
    wen = 1'b0;
    addr = '0;
    wdata = '0;
    byte_en = 4'b1111;
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if (busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy2 got %b want 0", busy2);
    end
    vectors++;
    if (error2 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_error2 got %b want 0", error2);
    end
    vectors++;
    if (rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_rdata2 got %h want 0", rdata2);
    end
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy0 got %b want 0", busy0);
    end
    vectors++;
    if (rdata0 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_rdata0 got %h want 0", rdata0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    int n;
    logic [31:0] rd;
    logic er;
    op2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, n, rd, er);
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL wr_busy_cycles got %0d want 2", n);
    end
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_error got %b want 0", er);
    end
    op2(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL rd_busy_cycles got %0d want 2", n);
    end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_word got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte_lane();
    int n;
    logic [31:0] rd;
    logic er;
    // byte 0xAA replicated on all lanes; only lane 1 enabled
    op2(1'b0, 1'b1, 32'h11, 32'hAAAAAAAA, 4'b0010, n, rd, er);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_wr_error got %b want 0", er);
    end
    op2(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'hDEADAAEF) begin
      miscompares++;
      $display("FAIL byte_merge got %h want deadaaef", rd);
    end
  endtask

  task automatic test_errors();
    int n;
    logic [31:0] rd;
    logic er;
    op2(1'b1, 1'b0, 32'h2000, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_rd_error got %b want 1", er);
    end
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_rd_data got %h want 0", rd);
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL oor_rd_cycles got %0d want 2", n);
    end
    // 0x2010 would alias word 4 if the fault did not block it
    op2(1'b0, 1'b1, 32'h2010, 32'h55555555, 4'b1111, n, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_wr_error got %b want 1", er);
    end
    op2(1'b1, 1'b0, 32'h12, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL word_misalign got %b want 1", er);
    end
    op2(1'b1, 1'b0, 32'h12, 32'h0, 4'b1100, n, rd, er);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL half_aligned_error got %b want 0", er);
    end
    vectors++;
    if (rd !== 32'hDEADAAEF) begin
      miscompares++;
      $display("FAIL half_aligned_data got %h want deadaaef", rd);
    end
    op2(1'b1, 1'b0, 32'h11, 32'h0, 4'b0011, n, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL half_misalign got %b want 1", er);
    end
    op2(1'b1, 1'b0, 32'h10, 32'h0, 4'b0101, n, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_byte_en got %b want 1", er);
    end
    op2(1'b1, 1'b1, 32'h10, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL ren_wen_error got %b want 1", er);
    end
    op2(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'hDEADAAEF) begin
      miscompares++;
      $display("FAIL err_no_write got %h want deadaaef", rd);
    end
  endtask

  task automatic test_abort();
    int n;
    logic [31:0] rd;
    logic er;
    ren = 1'b0;
    wen = 1'b1;
    addr = 32'h10;
    wdata = 32'h11111111;
    byte_en = 4'b1111;
    #2;
    vectors++;
    if (busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_req got %b want 1", busy2);
    end
    @(posedge clk);
    #1;
    wen = 1'b0;
    #2;
    vectors++;
    if (busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy_drop got %b want 0", busy2);
    end
    @(posedge clk);
    #1;
    op2(1'b0, 1'b1, 32'h14, 32'h22222222, 4'b1111, n, rd, er);
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL after_abort_cycles got %0d want 2", n);
    end
    op2(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'hDEADAAEF) begin
      miscompares++;
      $display("FAIL abort_no_write got %h want deadaaef", rd);
    end
    op2(1'b1, 1'b0, 32'h14, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'h22222222) begin
      miscompares++;
      $display("FAIL after_abort_data got %h want 22222222", rd);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] rd;
    logic er;
    op2(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b1111, n, rd, er);
    op2(1'b0, 1'b1, 32'h24, 32'h5A5A5A5A, 4'b1111, n, rd, er);
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL b2b_wr_cycles got %0d want 2", n);
    end
    op2(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL b2b_rd0 got %h want a5a5a5a5", rd);
    end
    op2(1'b1, 1'b0, 32'h24, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'h5A5A5A5A) begin
      miscompares++;
      $display("FAIL b2b_rd1 got %h want 5a5a5a5a", rd);
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL b2b_rd_cycles got %0d want 2", n);
    end
  endtask

  task automatic test_zero_latency();
    byte_en = 4'b1111;
    ren = 1'b0;
    wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h40 + 32'(4 * i);
      wdata = 32'hC0DE0000 + 32'(i);
      #2;
      vectors++;
      if (busy0 !== 1'b0 || error0 !== 1'b0) begin
        miscompares++;
        $display("FAIL lat0_wr%0d busy=%b err=%b want 0 0",
                 i, busy0, error0);
      end
      @(posedge clk);
      #1;
    end
    wen = 1'b0;
    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h40 + 32'(4 * i);
      #2;
      vectors++;
      if (busy0 !== 1'b0) begin
        miscompares++;
        $display("FAIL lat0_rd%0d_busy got %b want 0", i, busy0);
      end
      vectors++;
      if (rdata0 !== 32'hC0DE0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL lat0_rd%0d_data got %h want %h",
                 i, rdata0, 32'hC0DE0000 + 32'(i));
      end
      @(posedge clk);
      #1;
    end
    ren = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] rd;
    logic er;
    ren = 1'b1;
    wen = 1'b0;
    addr = 32'h10;
    byte_en = 4'b1111;
    @(posedge clk);
    #3;
    vectors++;
    if (busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_wait_busy got %b want 1", busy2);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_busy got %b want 0", busy2);
    end
    ren = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op2(1'b0, 1'b1, 32'h18, 32'h0BADF00D, 4'b1111, n, rd, er);
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL post_rst_cycles got %0d want 2", n);
    end
    op2(1'b1, 1'b0, 32'h18, 32'h0, 4'b1111, n, rd, er);
    vectors++;
    if (rd !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL post_rst_data got %h want 0badf00d", rd);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_byte_lane();
    test_errors();
    test_abort();
    test_back_to_back();
    test_zero_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
